// File: rtl/jtlabrun_romarb_if.sv
// Shared ROM read bus: main CPU byte port, GFX word port and the SDRAM read port.
// The arbiter uses the slave modport; clients and SDRAM controller use master.
interface jtlabrun_romarb_if #(
    parameter int MAIN_AW = 17,
    parameter int GFX_AW  = 20
);
    logic               flush;
    logic               main_cs;
    logic [MAIN_AW-1:0] main_addr;
    logic [7:0]         main_data;
    logic               main_ok;
    logic               gfx_cs;
    logic [GFX_AW-1:0]  gfx_addr;
    logic [31:0]        gfx_data;
    logic               gfx_ok;
    logic [21:0]        sdram_addr;
    logic               sdram_rd;
    logic               sdram_ack;
    logic               sdram_rdy;
    logic [31:0]        sdram_dout;

    modport slave (
        input  flush, main_cs, main_addr, gfx_cs, gfx_addr,
               sdram_ack, sdram_rdy, sdram_dout,
        output main_data, main_ok, gfx_data, gfx_ok, sdram_addr, sdram_rd
    );

    modport master (
        output flush, main_cs, main_addr, gfx_cs, gfx_addr,
               sdram_ack, sdram_rdy, sdram_dout,
        input  main_data, main_ok, gfx_data, gfx_ok, sdram_addr, sdram_rd
    );
endinterface

// File: rtl/jtlabrun_romarb.sv
// Two-client ROM read arbiter with a one-word hit cache per client; hits are combinational, misses take IDLE+REQ+WAIT.
// sdram_rd is held until sdram_ack; clients stall on *_ok, and GFX is forced after STARVE_MAX main grants.
module jtlabrun_romarb #(
    parameter int          MAIN_AW    = 17,
    parameter int          GFX_AW     = 20,
    parameter logic [21:0] GFX_OFFSET = 22'h8000,
    parameter int          STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    jtlabrun_romarb_if.slave bus
);
    localparam int MTW = MAIN_AW - 2;
    localparam int TW  = (MTW > GFX_AW) ? MTW : GFX_AW;
    localparam int SW  = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t             state_q, state_d;
    logic               sdram_rd_q, sdram_rd_d;
    logic [21:0]        sdram_addr_q, sdram_addr_d;
    logic               gnt_gfx_q, gnt_gfx_d;
    logic [TW-1:0]      lat_tag_q, lat_tag_d;
    logic               main_valid_q, main_valid_d;
    logic               gfx_valid_q, gfx_valid_d;
    logic [31:0]        main_cache_q, main_cache_d;
    logic [31:0]        gfx_cache_q, gfx_cache_d;
    logic [MTW-1:0]     main_tag_q, main_tag_d;
    logic [GFX_AW-1:0]  gfx_tag_q, gfx_tag_d;
    logic [SW-1:0]      starve_q, starve_d;

    logic [MTW-1:0] main_tag_in;
    logic           main_hit, gfx_hit, main_miss, gfx_miss, fill;

    assign main_tag_in = bus.main_addr[MAIN_AW-1:2];
    assign main_hit    = bus.main_cs & main_valid_q & (main_tag_in == main_tag_q);
    assign gfx_hit     = bus.gfx_cs & gfx_valid_q & (bus.gfx_addr == gfx_tag_q);
    assign main_miss   = bus.main_cs & ~main_hit;
    assign gfx_miss    = bus.gfx_cs & ~gfx_hit;

    assign bus.main_ok    = main_hit;
    assign bus.gfx_ok     = gfx_hit;
    assign bus.main_data  = main_cache_q[{bus.main_addr[1:0], 3'b000} +: 8];
    assign bus.gfx_data   = gfx_cache_q;
    assign bus.sdram_rd   = sdram_rd_q;
    assign bus.sdram_addr = sdram_addr_q;

    always_comb begin
        state_d      = state_q;
        sdram_rd_d   = sdram_rd_q;
        sdram_addr_d = sdram_addr_q;
        gnt_gfx_d    = gnt_gfx_q;
        lat_tag_d    = lat_tag_q;
        main_valid_d = main_valid_q;
        gfx_valid_d  = gfx_valid_q;
        main_cache_d = main_cache_q;
        gfx_cache_d  = gfx_cache_q;
        main_tag_d   = main_tag_q;
        gfx_tag_d    = gfx_tag_q;
        starve_d     = starve_q;
        fill         = 1'b0;

        case (state_q)
            IDLE: begin
                if (main_miss | gfx_miss) begin
                    if (main_miss && (!gfx_miss || starve_q < SMAX)) begin
                        gnt_gfx_d    = 1'b0;
                        lat_tag_d    = TW'(main_tag_in);
                        sdram_addr_d = 22'(main_tag_in);
                        starve_d     = gfx_miss ? starve_q + SW'(1) : '0;
                    end else begin
                        gnt_gfx_d    = 1'b1;
                        lat_tag_d    = TW'(bus.gfx_addr);
                        sdram_addr_d = GFX_OFFSET + 22'(bus.gfx_addr);
                        starve_d     = '0;
                    end
                    sdram_rd_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // ack and rdy in the same cycle skip WAIT entirely
                if (bus.sdram_ack) begin
                    sdram_rd_d = 1'b0;
                    if (bus.sdram_rdy) begin
                        fill    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.sdram_rdy) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!gfx_miss) starve_d = '0;

        // Fill uses the tag latched at grant, so a moved address simply misses afterwards
        if (fill) begin
            if (gnt_gfx_q) begin
                gfx_cache_d = bus.sdram_dout;
                gfx_tag_d   = lat_tag_q[GFX_AW-1:0];
                gfx_valid_d = 1'b1;
            end else begin
                main_cache_d = bus.sdram_dout;
                main_tag_d   = lat_tag_q[MTW-1:0];
                main_valid_d = 1'b1;
            end
        end

        if (bus.flush) begin
            main_valid_d = 1'b0;
            gfx_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sdram_rd_q   <= 1'b0;
            sdram_addr_q <= '0;
            gnt_gfx_q    <= 1'b0;
            lat_tag_q    <= '0;
            main_valid_q <= 1'b0;
            gfx_valid_q  <= 1'b0;
            main_cache_q <= '0;
            gfx_cache_q  <= '0;
            main_tag_q   <= '0;
            gfx_tag_q    <= '0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            sdram_rd_q   <= sdram_rd_d;
            sdram_addr_q <= sdram_addr_d;
            gnt_gfx_q    <= gnt_gfx_d;
            lat_tag_q    <= lat_tag_d;
            main_valid_q <= main_valid_d;
            gfx_valid_q  <= gfx_valid_d;
            main_cache_q <= main_cache_d;
            gfx_cache_q  <= gfx_cache_d;
            main_tag_q   <= main_tag_d;
            gfx_tag_q    <= gfx_tag_d;
            starve_q     <= starve_d;
        end
    end
endmodule

// File: tb/tb_jtlabrun_romarb.sv
// Bench for jtlabrun_romarb: SDRAM controller model with programmable ack/rdy delays,
// expected fetch addresses queued at stimulus time and compared as requests appear.
module tb_jtlabrun_romarb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    jtlabrun_romarb_if #(.MAIN_AW(17), .GFX_AW(20)) bus ();

    jtlabrun_romarb #(
        .MAIN_AW(17), .GFX_AW(20), .GFX_OFFSET(22'h8000), .STARVE_MAX(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [21:0] exp_q[$];
    int          ack_dly = 2;
    int          rdy_dly = 3;
    int          ctl_phase = 0;
    int          ctl_cnt = 0;
    logic [21:0] ctl_cur = '0;
    int          fill_cnt = 0;
    int          rdy_cyc = 0;
    bit          flush_req = 1'b0;
    bit          flush_on_rdy = 1'b0;
    bit          ctl_flushed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        if (a == 22'h1) return 32'hAABBCCDD;
        return {10'h2A5, a} ^ {a[15:0], 16'h5A3C};
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
        return w[{s, 3'b000} +: 8];
    endfunction

    task automatic drive_rdy();
        bus.sdram_rdy  = 1'b1;
        bus.sdram_dout = mem_word(ctl_cur);
        rdy_cyc        = cyc;
        fill_cnt++;
        ctl_phase      = 0;
        if (flush_on_rdy) begin
            bus.flush    = 1'b1;
            flush_on_rdy = 1'b0;
            ctl_flushed  = 1'b1;
        end
    endtask

    // SDRAM controller model and flush driver; all updates on the falling edge
    initial begin
        bus.sdram_ack  = 1'b0;
        bus.sdram_rdy  = 1'b0;
        bus.sdram_dout = '0;
        bus.flush      = 1'b0;
        forever begin
            @(negedge clk);
            bus.sdram_ack = 1'b0;
            bus.sdram_rdy = 1'b0;
            if (ctl_flushed) begin
                bus.flush   = 1'b0;
                ctl_flushed = 1'b0;
            end
            if (flush_req) begin
                bus.flush   = 1'b1;
                flush_req   = 1'b0;
                ctl_flushed = 1'b1;
            end
            if (rst) begin
                ctl_phase = 0;
            end else begin
                case (ctl_phase)
                    0: if (bus.sdram_rd) begin
                        ctl_cur = bus.sdram_addr;
                        if (exp_q.size() == 0) chk("sb_extra", 32'(exp_q.size()), 32'd1);
                        else chk("sb_addr", 32'(ctl_cur), 32'(exp_q.pop_front()));
                        ctl_cnt   = ack_dly;
                        ctl_phase = 1;
                    end
                    1: if (ctl_cnt <= 1) begin
                        chk("rd_hold", {9'd0, bus.sdram_rd, bus.sdram_addr}, {9'd0, 1'b1, ctl_cur});
                        bus.sdram_ack = 1'b1;
                        if (rdy_dly == 0) drive_rdy();
                        else begin
                            ctl_cnt   = rdy_dly;
                            ctl_phase = 2;
                        end
                    end else ctl_cnt--;
                    2: if (ctl_cnt <= 1) begin
                        chk("rd_drop", 32'(bus.sdram_rd), 32'd0);
                        drive_rdy();
                    end else ctl_cnt--;
                    default: ctl_phase = 0;
                endcase
            end
        end
    end

    task automatic wait_main_ok(input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge clk); #1;
            if (bus.main_ok) break;
        end
        chk("main_ok_wait", 32'(bus.main_ok), 32'd1);
    endtask

    task automatic wait_gfx_ok(input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge clk); #1;
            if (bus.gfx_ok) break;
        end
        chk("gfx_ok_wait", 32'(bus.gfx_ok), 32'd1);
    endtask

    task automatic wait_fill(input int target, input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge clk); #1;
            if (fill_cnt >= target) break;
        end
        chk("fill_wait", 32'(fill_cnt >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          fills;
        int          fc;
        logic [31:0] w;
        bus.main_cs   = 1'b1;
        bus.main_addr = 17'h00005;
        bus.gfx_cs    = 1'b0;
        bus.gfx_addr  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd", 32'(bus.sdram_rd), 32'd0);
        chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
        chk("rst_main_ok", 32'(bus.main_ok), 32'd0);
        chk("rst_gfx_ok", 32'(bus.gfx_ok), 32'd0);
        chk("rst_main_data", 32'(bus.main_data), 32'd0);
        chk("rst_gfx_data", bus.gfx_data, 32'd0);

        // main miss at byte 5 -> word 1
        exp_q.push_back(22'h000001);
        @(negedge clk);
        rst = 1'b0;
        wait_main_ok(30);
        chk("m_lat", 32'(cyc - rdy_cyc), 32'd1);
        chk("m_byte5", 32'(bus.main_data), 32'hCC);

        w = 32'hAABBCCDD;
        for (int i = 4; i < 8; i++) begin
            bus.main_addr = 17'(i);
            #1;
            chk("m_hit_ok", 32'(bus.main_ok), 32'd1);
            chk("m_hit_byte", 32'(bus.main_data), 32'(byte_of(w, 2'(i))));
            chk("m_hit_nord", 32'(bus.sdram_rd), 32'd0);
        end

        // gfx miss with offset, then ack+rdy in the same cycle
        exp_q.push_back(22'h008010);
        bus.gfx_cs   = 1'b1;
        bus.gfx_addr = 20'h00010;
        wait_gfx_ok(30);
        chk("g_data", bus.gfx_data, mem_word(22'h008010));
        rdy_dly = 0;
        exp_q.push_back(22'h008011);
        bus.gfx_addr = 20'h00011;
        wait_gfx_ok(30);
        chk("g_lat_same", 32'(cyc - rdy_cyc), 32'd1);
        chk("g_data_same", bus.gfx_data, mem_word(22'h008011));

        // both streaming misses: order M,M,M,G,M,M,M,G enforced by queue order
        ack_dly = 1;
        rdy_dly = 1;
        exp_q.push_back(22'h000400); exp_q.push_back(22'h000401);
        exp_q.push_back(22'h000402); exp_q.push_back(22'h008100);
        exp_q.push_back(22'h000403); exp_q.push_back(22'h000404);
        exp_q.push_back(22'h000405); exp_q.push_back(22'h008101);
        bus.main_addr = 17'h01000;
        bus.gfx_addr  = 20'h00100;
        fills = 0;
        for (int n = 0; n < 300 && fills < 8; n++) begin
            @(negedge clk); #1;
            if (bus.main_ok) begin
                chk("grant_m_dat", 32'(bus.main_data),
                    32'(byte_of(mem_word(22'(bus.main_addr >> 2)), 2'd0)));
                bus.main_addr = bus.main_addr + 17'd4;
                fills++;
            end
            if (bus.gfx_ok) begin
                chk("grant_g_dat", bus.gfx_data, mem_word(22'h8000 + 22'(bus.gfx_addr)));
                bus.gfx_addr = bus.gfx_addr + 20'd1;
                fills++;
            end
            if (fills == 8) begin
                bus.main_cs = 1'b0;
                bus.gfx_cs  = 1'b0;
            end
        end
        chk("grant_fills", 32'(fills), 32'd8);
        bus.main_cs = 1'b0;
        bus.gfx_cs  = 1'b0;

        // address moves while the fetch is in WAIT
        ack_dly = 1;
        rdy_dly = 4;
        exp_q.push_back(22'h000040);
        exp_q.push_back(22'h000080);
        @(negedge clk);
        bus.main_addr = 17'h00100;
        bus.main_cs   = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk); #1;
            if (ctl_phase == 2) break;
        end
        chk("chg_in_wait", 32'(ctl_phase), 32'd2);
        bus.main_addr = 17'h00200;
        #1;
        chk("chg_ok_drop", 32'(bus.main_ok), 32'd0);
        fc = fill_cnt;
        wait_fill(fc + 1, 30);
        @(negedge clk); #1;
        chk("chg_miss", 32'(bus.main_ok), 32'd0);
        bus.main_addr = 17'h00100;
        #1;
        chk("chg_old_tag", 32'(bus.main_ok), 32'd1);
        chk("chg_old_dat", 32'(bus.main_data), 32'(byte_of(mem_word(22'h40), 2'd0)));
        bus.main_addr = 17'h00200;
        wait_main_ok(30);
        chk("chg_new_dat", 32'(bus.main_data), 32'(byte_of(mem_word(22'h80), 2'd0)));

        // flush pulse with both caches warm
        ack_dly = 1;
        rdy_dly = 1;
        bus.gfx_addr = 20'h00101;
        bus.gfx_cs   = 1'b1;
        #1;
        chk("pre_flush_g", 32'(bus.gfx_ok), 32'd1);
        chk("pre_flush_m", 32'(bus.main_ok), 32'd1);
        exp_q.push_back(22'h000080);
        exp_q.push_back(22'h008101);
        flush_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("flush_m_ok", 32'(bus.main_ok), 32'd0);
        chk("flush_g_ok", 32'(bus.gfx_ok), 32'd0);
        wait_main_ok(30);
        wait_gfx_ok(30);
        chk("refetch_g", bus.gfx_data, mem_word(22'h008101));

        // flush coinciding with the fill wins over the valid set
        bus.gfx_cs = 1'b0;
        exp_q.push_back(22'h0000C0);
        exp_q.push_back(22'h0000C0);
        flush_on_rdy  = 1'b1;
        bus.main_addr = 17'h00302;
        fc = fill_cnt;
        wait_fill(fc + 1, 30);
        @(negedge clk); #1;
        chk("flush_fill_ok", 32'(bus.main_ok), 32'd0);
        wait_main_ok(30);
        chk("flush_fill_dat", 32'(bus.main_data), 32'(byte_of(mem_word(22'hC0), 2'd2)));

        // reset while a request is outstanding
        ack_dly = 50;
        exp_q.push_back(22'h000100);
        bus.main_addr = 17'h00400;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk); #1;
            if (bus.sdram_rd) break;
        end
        chk("req_seen", 32'(bus.sdram_rd), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_rd", 32'(bus.sdram_rd), 32'd0);
        chk("arst_addr", 32'(bus.sdram_addr), 32'd0);
        chk("arst_ok", 32'(bus.main_ok), 32'd0);
        bus.main_cs = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_dly = 2;
        repeat (5) @(negedge clk);
        #1;
        chk("post_rst_rd", 32'(bus.sdram_rd), 32'd0);
        chk("sb_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
